wishbone_addr_demux1to3: RTL and testbench
==========================================

Name: wishbone_addr_demux1to3

Overview:
- Single-master to three-slave Wishbone address decoder/router. This is the fan-out counterpart of the master-select mux.
- Sits between one Wishbone initiator (e.g. the UART bridge/core) and up to three peripheral responders.
- Decodes the address, holds the selected target for the whole cycle, and forwards the handshake.
- Generates an error response for unmapped addresses and for slaves that never respond (timeout).

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; SEL_W = DATA_W/8
- BASE0 / BASE1 / BASE2, 32'h0000_0000 / 32'h0000_1000 / 32'h0000_2000, slave base addresses
- MASK0 / MASK1 / MASK2, 32'hFFFF_F000 each, address match masks; slave i hits when (m_addr & MASKi) == BASEi
- TIMEOUT, 255, maximum wait cycles for a slave ack (8-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- m_cyc, m_stb, m_we  in  1 each  master cycle, strobe, write enable
- m_addr  in  ADDR_W  master address
- m_dat_o  in  DATA_W  master write data
- m_sel  in  SEL_W  master byte select
- m_dat_i  out  DATA_W  read data returned to master
- m_ack  out  1  transfer acknowledge to master
- m_err  out  1  error terminate to master (unmapped address or timeout)
- s_cyc, s_stb  out  3 each  per-slave cycle and strobe (one-hot or zero)
- s_we  out  1  broadcast write enable
- s_addr  out  ADDR_W  broadcast address
- s_dat_o  out  DATA_W  broadcast write data
- s_sel  out  SEL_W  broadcast byte select
- s_ack  in  3  per-slave acknowledge
- s_dat_i  in  3*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, sel_idx=0, timeout counter=0.
  - m_ack=0, m_err=0, m_dat_i=0, s_cyc=0, s_stb=0.
  - Reset mid-transfer abandons the transfer with no ack/err pulse.
- States: IDLE, ACTIVE, ERROR.
- IDLE:
  - On m_cyc&m_stb, decode m_addr; the lowest matching index wins on overlap.
  - Hit: register sel_idx, clear counter, go to ACTIVE.
  - No hit: go to ERROR.
  - No slave strobes are asserted in IDLE. The decode adds one cycle of latency.
- ACTIVE:
  - s_cyc[sel_idx]=m_cyc and s_stb[sel_idx]=m_stb; the other slaves are held at 0.
  - s_we/s_addr/s_dat_o/s_sel are combinational copies of the master signals at all times.
  - m_ack = s_ack[sel_idx] and m_dat_i = s_dat_i[sel_idx], both combinational. Acks from unselected slaves are ignored.
  - If s_ack[sel_idx]=1, go to IDLE.
  - Else if m_cyc=0 (master abort), go to IDLE with no ack/err.
  - Else the counter increments. When the counter==TIMEOUT and there is no ack: force s_cyc/s_stb to 0 that cycle and go to ERROR.
  - Ack and timeout in the same cycle: ack wins, no error.
- ERROR:
  - m_err=1 for exactly one cycle; m_ack=0, m_dat_i=0, all s_cyc/s_stb=0.
  - Then go to IDLE.
- m_dat_i=0 whenever m_ack=0.
- m_ack and m_err are never both 1.
- Back-to-back transfers: after an ack, a new strobe held high is decoded in the next IDLE cycle. Minimum of 2 cycles per transfer with a zero-wait slave.
- The counter saturates and never wraps. It is cleared on entry to ACTIVE.

Test Plan:
- Reset: assert rst for 3 cycles mid-ACTIVE, then release -> m_ack=0, m_err=0, s_cyc=3'b000, s_stb=3'b000, state IDLE; no spurious ack afterwards.
- Read slave1: m_addr=32'h0000_1004 with m_cyc=m_stb=1 and m_we=0; slave1 acks in its 2nd strobed cycle with s_dat_i slice 32'hDEAD_BEEF -> s_stb=3'b010 from cycle+1, m_ack=1 with m_dat_i=32'hDEAD_BEEF; s_stb returns to 0 after the ack.
- Write slave2: m_addr=32'h0000_2010, m_dat_o=32'h1234_5678, m_sel=4'hF, m_we=1; zero-wait ack -> s_stb=3'b100, s_dat_o=32'h1234_5678, m_ack pulses 1 cycle; slaves 0 and 1 never strobed.
- Unmapped: m_addr=32'h0000_8000 -> no s_stb asserted, m_err=1 exactly one cycle (2nd cycle after strobe), m_ack=0.
- Timeout: slave0 never acks -> s_stb[0] is high for the TIMEOUT wait cycles, then drops, then m_err pulses once; with s_ack[0]=1 on the expiry cycle -> m_ack=1 and m_err stays 0.
- Stray ack/abort: s_ack[1]=1 while slave0 is selected -> m_ack stays 0; m_cyc dropped mid-ACTIVE -> IDLE next cycle with no ack/err.

Source files
------------

// File: rtl/wishbone_addr_demux1to3.sv
// Wishbone 1-master to 3-slave address router.
// Decodes the address once per cycle, holds the target, and terminates unmapped or stalled cycles with an error.
module wishbone_addr_demux1to3 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = DATA_W / 8,
    parameter logic [ADDR_W-1:0] BASE0 = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] BASE1 = 32'h0000_1000,
    parameter logic [ADDR_W-1:0] BASE2 = 32'h0000_2000,
    parameter logic [ADDR_W-1:0] MASK0 = 32'hFFFF_F000,
    parameter logic [ADDR_W-1:0] MASK1 = 32'hFFFF_F000,
    parameter logic [ADDR_W-1:0] MASK2 = 32'hFFFF_F000,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_cyc,
    input  logic                  m_stb,
    input  logic                  m_we,
    input  logic [ADDR_W-1:0]     m_addr,
    input  logic [DATA_W-1:0]     m_dat_o,
    input  logic [SEL_W-1:0]      m_sel,
    output logic [DATA_W-1:0]     m_dat_i,
    output logic                  m_ack,
    output logic                  m_err,
    output logic [2:0]            s_cyc,
    output logic [2:0]            s_stb,
    output logic                  s_we,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_dat_o,
    output logic [SEL_W-1:0]      s_sel,
    input  logic [2:0]            s_ack,
    input  logic [3*DATA_W-1:0]   s_dat_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ERROR
    } state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t state, state_n;
    logic [1:0] sel_idx, sel_idx_n;
    logic [7:0] cnt, cnt_n;

    logic [2:0]        hit;
    logic              hit_any;
    logic [1:0]        hit_idx;
    logic              sel_ack;
    logic [DATA_W-1:0] sel_dat;
    logic [2:0]        sel_oh;
    logic              expire;

    assign s_we    = m_we;
    assign s_addr  = m_addr;
    assign s_dat_o = m_dat_o;
    assign s_sel   = m_sel;

    assign hit[0]  = (m_addr & MASK0) == BASE0;
    assign hit[1]  = (m_addr & MASK1) == BASE1;
    assign hit[2]  = (m_addr & MASK2) == BASE2;
    assign hit_any = |hit;

    // Lowest index wins when windows overlap
    always_comb begin
        hit_idx = 2'd2;
        if (hit[0]) begin
            hit_idx = 2'd0;
        end else if (hit[1]) begin
            hit_idx = 2'd1;
        end
    end

    always_comb begin
        sel_ack = s_ack[2];
        sel_dat = s_dat_i[2*DATA_W +: DATA_W];
        sel_oh  = 3'b100;
        unique case (sel_idx)
            2'd0: begin
                sel_ack = s_ack[0];
                sel_dat = s_dat_i[0 +: DATA_W];
                sel_oh  = 3'b001;
            end
            2'd1: begin
                sel_ack = s_ack[1];
                sel_dat = s_dat_i[DATA_W +: DATA_W];
                sel_oh  = 3'b010;
            end
            default: begin
                sel_ack = s_ack[2];
                sel_dat = s_dat_i[2*DATA_W +: DATA_W];
                sel_oh  = 3'b100;
            end
        endcase
    end

    // An ack on the expiry cycle still completes the transfer normally
    assign expire = m_cyc && !sel_ack && (cnt == TO_CNT);

    always_comb begin
        state_n   = state;
        sel_idx_n = sel_idx;
        cnt_n     = cnt;
        m_ack     = 1'b0;
        m_err     = 1'b0;
        m_dat_i   = '0;
        s_cyc     = 3'b000;
        s_stb     = 3'b000;
        unique case (state)
            IDLE: begin
                if (m_cyc && m_stb) begin
                    if (hit_any) begin
                        sel_idx_n = hit_idx;
                        cnt_n     = 8'd0;
                        state_n   = ACTIVE;
                    end else begin
                        state_n = ERROR;
                    end
                end
            end
            ACTIVE: begin
                m_ack = sel_ack;
                if (sel_ack) begin
                    m_dat_i = sel_dat;
                end
                if (!expire) begin
                    s_cyc = sel_oh & {3{m_cyc}};
                    s_stb = sel_oh & {3{m_stb}};
                end
                if (sel_ack) begin
                    state_n = IDLE;
                end else if (!m_cyc) begin
                    state_n = IDLE;
                end else if (expire) begin
                    state_n = ERROR;
                end else if (cnt != 8'hFF) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            ERROR: begin
                m_err   = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_idx <= 2'd0;
            cnt     <= 8'd0;
        end else begin
            state   <= state_n;
            sel_idx <= sel_idx_n;
            cnt     <= cnt_n;
        end
    end

endmodule

// File: tb/tb_wishbone_addr_demux1to3.sv
// Directed bench for the Wishbone 1-to-3 address router.
// Responses are predicted into a queue at request time and popped on ack/err.
module tb_wishbone_addr_demux1to3;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_addr, m_dat_o;
    logic [3:0]  m_sel;
    logic [31:0] m_dat_i;
    logic        m_ack, m_err;
    logic [2:0]  s_cyc, s_stb;
    logic        s_we;
    logic [31:0] s_addr, s_dat_o;
    logic [3:0]  s_sel;
    logic [2:0]  s_ack;
    logic [95:0] s_dat_i;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int high;

    always #5 clk = ~clk;

    wishbone_addr_demux1to3 dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_addr(m_addr), .m_dat_o(m_dat_o), .m_sel(m_sel),
        .m_dat_i(m_dat_i), .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_addr(s_addr), .s_dat_o(s_dat_o), .s_sel(s_sel),
        .s_ack(s_ack), .s_dat_i(s_dat_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push(input logic err, input logic [31:0] data);
        resp_t r;
        r.err  = err;
        r.data = data;
        exp_q.push_back(r);
    endtask

    task automatic pop_chk(input string tag);
        resp_t r;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL %s: observed empty queue expected a response", tag);
        end
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk({tag, "_err"}, 64'(m_err), 64'(r.err));
            chk({tag, "_ack"}, 64'(m_ack), 64'(!r.err));
            chk({tag, "_dat"}, 64'(m_dat_i), 64'(r.data));
        end
    endtask

    task automatic idle_master();
        m_cyc = 1'b0;
        m_stb = 1'b0;
        m_we  = 1'b0;
    endtask

    task automatic start(input logic [31:0] a, input logic we);
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        m_we   = we;
        m_addr = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        idle_master();
        m_addr  = '0;
        m_dat_o = '0;
        m_sel   = 4'h0;
        s_ack   = 3'b000;
        s_dat_i = '0;
        repeat (3) nxt();
        smp();
        chk("rst_ack", 64'(m_ack), 64'd0);
        chk("rst_err", 64'(m_err), 64'd0);
        chk("rst_cyc", 64'(s_cyc), 64'd0);
        chk("rst_stb", 64'(s_stb), 64'd0);
        chk("rst_dat", 64'(m_dat_i), 64'd0);

        // read from slave1, ack on its second strobed cycle
        nxt();
        rst = 1'b0;
        start(32'h0000_1004, 1'b0);
        s_dat_i[32 +: 32] = 32'hDEAD_BEEF;
        push(1'b0, 32'hDEAD_BEEF);
        smp();
        chk("rd_decode_stb", 64'(s_stb), 64'd0);
        chk("rd_decode_ack", 64'(m_ack), 64'd0);
        nxt();
        smp();
        chk("rd_w1_stb", 64'(s_stb), 64'b010);
        chk("rd_w1_cyc", 64'(s_cyc), 64'b010);
        chk("rd_w1_ack", 64'(m_ack), 64'd0);
        chk("rd_w1_dat", 64'(m_dat_i), 64'd0);
        nxt();
        s_ack = 3'b010;
        smp();
        chk("rd_w2_stb", 64'(s_stb), 64'b010);
        chk("rd_addr", 64'(s_addr), 64'h0000_1004);
        pop_chk("rd_resp");
        nxt();
        s_ack = 3'b000;
        idle_master();
        smp();
        chk("rd_after_stb", 64'(s_stb), 64'd0);
        chk("rd_after_ack", 64'(m_ack), 64'd0);

        // zero-wait write to slave2
        nxt();
        start(32'h0000_2010, 1'b1);
        m_dat_o = 32'h1234_5678;
        m_sel   = 4'hF;
        s_dat_i[64 +: 32] = 32'hA5A5_0002;
        push(1'b0, 32'hA5A5_0002);
        smp();
        chk("wr_decode_stb", 64'(s_stb), 64'd0);
        nxt();
        s_ack = 3'b100;
        smp();
        chk("wr_stb", 64'(s_stb), 64'b100);
        chk("wr_dat_o", 64'(s_dat_o), 64'h1234_5678);
        chk("wr_we", 64'(s_we), 64'd1);
        chk("wr_sel", 64'(s_sel), 64'hF);
        pop_chk("wr_resp");
        nxt();
        s_ack = 3'b000;
        idle_master();
        smp();
        chk("wr_after_ack", 64'(m_ack), 64'd0);
        chk("wr_after_stb", 64'(s_stb), 64'd0);

        // unmapped address
        nxt();
        start(32'h0000_8000, 1'b0);
        push(1'b1, 32'h0);
        smp();
        chk("um_c1_stb", 64'(s_stb), 64'd0);
        chk("um_c1_err", 64'(m_err), 64'd0);
        nxt();
        smp();
        chk("um_c2_stb", 64'(s_stb), 64'd0);
        pop_chk("um_resp");
        nxt();
        idle_master();
        smp();
        chk("um_c3_err", 64'(m_err), 64'd0);

        // slave0 never acks
        nxt();
        start(32'h0000_0040, 1'b0);
        push(1'b1, 32'h0);
        smp();
        high = 0;
        for (int i = 0; i < 300; i++) begin
            nxt();
            smp();
            if (s_stb == 3'b001 && m_err == 1'b0) begin
                high++;
            end else begin
                break;
            end
        end
        chk("to_high_cycles", 64'(high), 64'd255);
        chk("to_expiry_stb", 64'(s_stb), 64'd0);
        chk("to_expiry_err", 64'(m_err), 64'd0);
        nxt();
        smp();
        pop_chk("to_resp");
        nxt();
        idle_master();
        smp();
        chk("to_after_err", 64'(m_err), 64'd0);

        // ack arrives on the expiry cycle
        nxt();
        start(32'h0000_0000, 1'b0);
        s_dat_i[0 +: 32] = 32'hCAFE_0000;
        push(1'b0, 32'hCAFE_0000);
        smp();
        repeat (255) nxt();
        smp();
        chk("toack_pre_stb", 64'(s_stb), 64'b001);
        nxt();
        s_ack = 3'b001;
        smp();
        chk("toack_stb", 64'(s_stb), 64'b001);
        pop_chk("toack_resp");
        nxt();
        s_ack = 3'b000;
        idle_master();
        smp();
        chk("toack_after_err", 64'(m_err), 64'd0);
        nxt();
        smp();
        chk("toack_after2_err", 64'(m_err), 64'd0);

        // stray ack from slave1 while slave0 selected, then abort
        nxt();
        start(32'h0000_0010, 1'b0);
        smp();
        nxt();
        s_ack = 3'b010;
        smp();
        chk("stray_stb", 64'(s_stb), 64'b001);
        chk("stray_ack", 64'(m_ack), 64'd0);
        chk("stray_dat", 64'(m_dat_i), 64'd0);
        nxt();
        s_ack = 3'b000;
        idle_master();
        smp();
        chk("abort_ack", 64'(m_ack), 64'd0);
        chk("abort_err", 64'(m_err), 64'd0);
        chk("abort_stb", 64'(s_stb), 64'd0);
        nxt();
        smp();
        chk("abort_idle_err", 64'(m_err), 64'd0);
        chk("abort_idle_cyc", 64'(s_cyc), 64'd0);

        // reset during ACTIVE
        nxt();
        start(32'h0000_1000, 1'b0);
        smp();
        nxt();
        smp();
        chk("mrst_active_stb", 64'(s_stb), 64'b010);
        nxt();
        rst = 1'b1;
        repeat (3) nxt();
        smp();
        chk("mrst_ack", 64'(m_ack), 64'd0);
        chk("mrst_err", 64'(m_err), 64'd0);
        chk("mrst_cyc", 64'(s_cyc), 64'd0);
        chk("mrst_stb", 64'(s_stb), 64'd0);
        nxt();
        rst = 1'b0;
        idle_master();
        s_ack = 3'b010;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("post_rst_ack", 64'(m_ack), 64'd0);
            chk("post_rst_err", 64'(m_err), 64'd0);
            nxt();
        end
        s_ack = 3'b000;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
